// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
// State encoding, port selects and the NOP used on aborted fetches.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/unified_memory_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the memory.
// master = arbiter view, slave = pipeline + memory view.
interface unified_memory_arbiter_if #(
  parameter int nbits = 32
);

  logic             if_req;
  logic [nbits-1:0] if_addr;
  logic [nbits-1:0] if_rdata;
  logic             if_ready;

  logic             dm_read;
  logic             dm_write;
  logic [nbits-1:0] dm_addr;
  logic [nbits-1:0] dm_wdata;
  logic [nbits-1:0] dm_rdata;
  logic             dm_ready;

  logic             mem_req;
  logic             mem_we;
  logic [nbits-1:0] mem_addr;
  logic [nbits-1:0] mem_wdata;
  logic [nbits-1:0] mem_rdata;
  logic             mem_ack;

  logic             stall_fetch;
  logic             stall_mem;
  logic             timeout_err;

  modport master (
    input  if_req, if_addr,
    input  dm_read, dm_write,
    input  dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output stall_fetch, stall_mem,
    output timeout_err
  );

  modport slave (
    output if_req, if_addr,
    output dm_read, dm_write,
    output dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  stall_fetch, stall_mem,
    input  timeout_err
  );

endinterface

// File: rtl/unified_memory_arbiter_wait_timer.sv
// Wait-state counter for one memory transaction.
// Load wins over clear; counting stops at the terminal count.
module wait_timer #(
  parameter int max_wait = 15,
  parameter int w        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [w-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [w-1:0] cnt;

  assign tc = (cnt == w'(max_wait));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Single-port memory arbiter between fetch and MEM stage.
// Grant FSM with wait-state timeout and fetch starvation guard.
module unified_memory_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int nbits        = 32,
  parameter int max_wait     = 15,
  parameter int starve_limit = 3
) (
  input  logic clk,
  input  logic reset,
  unified_memory_arbiter_if.master bus
);

  localparam int WW = cnt_width(max_wait);
  localparam int SW = cnt_width(starve_limit);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          sel;
  logic [SW-1:0] starve_cnt;
  logic          wait_tc;

  logic dm_any;
  logic starved;
  logic dm_fair;
  logic grant_dm;
  logic grant_if;
  logic busy;
  logic abort;

  assign dm_any  = bus.dm_read | bus.dm_write;
  assign starved = (starve_cnt >= SW'(starve_limit));
  assign dm_fair = dm_any & ~starved;
  assign busy    = (state == ST_BUSY_IF) ||
                   (state == ST_BUSY_DM);
  assign abort   = busy & ~bus.mem_ack & wait_tc;

  // Mutually exclusive grant terms; data falls back
  // to winning when fetch is not actually waiting.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == ST_IDLE) begin
      unique case (1'b1)
        dm_fair:
          grant_dm = 1'b1;
        bus.if_req & ~dm_fair:
          grant_if = 1'b1;
        dm_any & starved & ~bus.if_req:
          grant_dm = 1'b1;
        default: ;
      endcase
    end
  end

  wait_timer #(
    .max_wait (max_wait),
    .w        (WW)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .clr      (~busy),
    .load     (grant_dm | grant_if),
    .load_val (WW'(1)),
    .en       (busy),
    .tc       (wait_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_dm) begin
          state_nxt = ST_BUSY_DM;
        end else if (grant_if) begin
          state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (bus.mem_ack || wait_tc) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req  = busy;
    bus.if_ready = 1'b0;
    bus.dm_ready = 1'b0;
    if (state == ST_RESP) begin
      bus.if_ready = (sel == SEL_IF);
      bus.dm_ready = (sel == SEL_DM);
    end
  end

  assign bus.stall_fetch = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem   = dm_any & ~bus.dm_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && bus.if_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel             <= SEL_IF;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.if_rdata    <= '0;
      bus.dm_rdata    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      if (grant_dm) begin
        sel           <= SEL_DM;
        bus.mem_we    <= bus.dm_write;
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_wdata <= bus.dm_wdata;
      end else if (grant_if) begin
        sel           <= SEL_IF;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.if_addr;
      end
      if (busy && bus.mem_ack) begin
        if (sel == SEL_IF) begin
          bus.if_rdata <= bus.mem_rdata;
        end else if (!bus.mem_we) begin
          bus.dm_rdata <= bus.mem_rdata;
        end
      end else if (abort) begin
        bus.timeout_err <= 1'b1;
        if (sel == SEL_IF) begin
          bus.if_rdata <= nbits'(NOP_INSTR);
        end else begin
          bus.dm_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboard bench for the fetch/data memory arbiter.
// Ready pulses are popped against expectations queued at request time.
module tb_unified_memory_arbiter;

  localparam logic [31:0] K   = 32'h1234_5678;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  unified_memory_arbiter_if #(.nbits(32)) bus ();

  unified_memory_arbiter #(
    .nbits        (32),
    .max_wait     (15),
    .starve_limit (3)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_dm;

  logic        ack_en;
  int          ack_delay;
  int          busy_cyc;
  logic        use_ovr;
  logic [31:0] ovr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  assign bus.mem_ack   = bus.mem_req && ack_en &&
                         (busy_cyc == ack_delay);
  assign bus.mem_rdata = use_ovr ? ovr : (bus.mem_addr ^ K);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cyc <= 0;
    else if (bus.mem_req && !bus.mem_ack) busy_cyc <= busy_cyc + 1;
    else busy_cyc <= 0;
  end

  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack && bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n && (bus.if_ready || bus.dm_ready)) begin
      exp_t        e;
      logic        p;
      logic [31:0] d;
      p = bus.dm_ready;
      d = p ? bus.dm_rdata : bus.if_rdata;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected port=%0d data=%h required=none",
                 p, d);
      end else begin
        e = sb.pop_front();
        if (e.port !== p || e.data !== d) begin
          bad++;
          $display("FAIL sb_data port=%0d data=%h required port=%0d data=%h",
                   p, d, e.port, e.data);
        end
      end
    end
  end

  task automatic run_if(input logic [31:0] a, output int lat,
                        output int req_cyc, output logic [31:0] g_addr,
                        output logic stall_ok);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    lat = 0; req_cyc = 0; g_addr = '0; stall_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) begin
        req_cyc++;
        if (req_cyc == 1) g_addr = bus.mem_addr;
      end
      if (bus.if_ready) break;
      if (!bus.stall_fetch) stall_ok = 1'b0;
    end
    if (!bus.if_ready) begin
      total++; bad++;
      $display("FAIL if_wait no if_ready after 100 cycles");
    end
    bus.if_req = 1'b0;
  endtask

  task automatic run_dm(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] g_addr,
                        output logic g_we);
    bus.dm_read  = rd;
    bus.dm_write = wr;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    lat = 0; g_addr = '0; g_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        g_addr = bus.mem_addr;
        g_we   = bus.mem_we;
      end
      if (bus.dm_ready) break;
    end
    if (!bus.dm_ready) begin
      total++; bad++;
      $display("FAIL dm_wait no dm_ready after 100 cycles");
    end
    bus.dm_read  = 1'b0;
    bus.dm_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_read = 0; bus.dm_write = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0;
    ack_en = 1'b1; ack_delay = 0; use_ovr = 1'b0; ovr = '0;
    exp_dm = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.dm_ready,
         bus.timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {bus.mem_req, bus.mem_we, bus.if_ready,
                bus.dm_ready, bus.timeout_err});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata,
         bus.dm_rdata} !== 128'h0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h required=0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int lat, rc;
    logic [31:0] ga;
    logic sok;
    ack_delay = 1; use_ovr = 1'b1; ovr = 32'h0050_0093;
    sb.push_back('{1'b0, 32'h0050_0093});
    run_if(32'h100, lat, rc, ga, sok);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL fetch_lat got=%0d required=3", lat);
    end
    total++;
    if (ga !== 32'h100) begin
      bad++; $display("FAIL fetch_addr got=%h required=100", ga);
    end
    total++;
    if (sok !== 1'b1 || bus.stall_fetch !== 1'b0) begin
      bad++;
      $display("FAIL fetch_stall got=%b/%b required=1/0",
               sok, bus.stall_fetch);
    end
    @(negedge clk);
    total++;
    if (bus.if_ready !== 1'b0) begin
      bad++; $display("FAIL fetch_pulse got=%b required=0", bus.if_ready);
    end
    use_ovr = 1'b0;
  endtask

  task automatic test_priority();
    int ldm, lif, rc;
    logic [31:0] ga, gi;
    logic gwe, sok;
    ack_delay = 0;
    sb.push_back('{1'b1, exp_dm});
    sb.push_back('{1'b0, 32'h700 ^ K});
    fork
      run_dm(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, ldm, ga, gwe);
      run_if(32'h700, lif, rc, gi, sok);
    join
    total++;
    if (ga !== 32'h10 || gwe !== 1'b1) begin
      bad++;
      $display("FAIL prio_grant addr=%h we=%b required=10/1", ga, gwe);
    end
    total++;
    if (ldm !== 2 || lif !== 5) begin
      bad++;
      $display("FAIL prio_lat dm=%0d if=%0d required=2/5", ldm, lif);
    end
    total++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h10 ||
        wr_data_q[0] !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL prio_write count=%0d required one write 10/deadbeef",
               wr_addr_q.size());
    end
  endtask

  task automatic test_starve();
    int n_dm;
    logic prev;
    logic [31:0] grants[$];
    ack_delay = 0;
    n_dm = 0; prev = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b1, 32'h200 ^ K});
    sb.push_back('{1'b0, 32'h300 ^ K});
    exp_dm = 32'h200 ^ K;
    bus.dm_read = 1'b1; bus.dm_addr = 32'h200;
    bus.if_req  = 1'b1; bus.if_addr = 32'h300;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_req && !prev) grants.push_back(bus.mem_addr);
      prev = bus.mem_req;
      if (bus.dm_ready) n_dm++;
      if (bus.if_ready) break;
    end
    total++;
    if (!bus.if_ready) begin
      bad++; $display("FAIL starve_wait no if_ready");
    end
    bus.if_req = 1'b0; bus.dm_read = 1'b0;
    total++;
    if (n_dm !== 3) begin
      bad++; $display("FAIL starve_count got=%0d required=3", n_dm);
    end
    total++;
    if (grants.size() != 4 || grants[0] !== 32'h200 ||
        grants[2] !== 32'h200 || grants[3] !== 32'h300) begin
      bad++;
      $display("FAIL starve_order grants=%0d required 200,200,200,300",
               grants.size());
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, rc;
    logic [31:0] ga;
    logic sok;
    ack_en = 1'b0;
    sb.push_back('{1'b0, NOP});
    run_if(32'h400, lat, rc, ga, sok);
    total++;
    if (lat !== 16 || rc !== 15) begin
      bad++;
      $display("FAIL timeout_len lat=%0d req=%0d required=16/15", lat, rc);
    end
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_flag got=%b required=1", bus.timeout_err);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_rw_both();
    int lat;
    logic [31:0] ga;
    logic gwe;
    ack_delay = 0;
    sb.push_back('{1'b1, 32'h30 ^ K});
    exp_dm = 32'h30 ^ K;
    run_dm(1'b1, 1'b0, 32'h30, 32'h0, lat, ga, gwe);
    @(negedge clk);
    sb.push_back('{1'b1, exp_dm});
    run_dm(1'b1, 1'b1, 32'h20, 32'h55AA_33CC, lat, ga, gwe);
    total++;
    if (gwe !== 1'b1 || ga !== 32'h20) begin
      bad++; $display("FAIL rw_we we=%b addr=%h required=1/20", gwe, ga);
    end
    total++;
    if (wr_addr_q[$] !== 32'h20 || wr_data_q[$] !== 32'h55AA_33CC) begin
      bad++;
      $display("FAIL rw_write got=%h/%h required=20/55aa33cc",
               wr_addr_q[$], wr_data_q[$]);
    end
    @(negedge clk);
    total++;
    if (bus.dm_rdata !== exp_dm) begin
      bad++;
      $display("FAIL rw_rdata got=%h required=%h", bus.dm_rdata, exp_dm);
    end
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++; $display("FAIL sticky_err got=%b required=1", bus.timeout_err);
    end
  endtask

  task automatic test_drop();
    logic seen, extra;
    ack_delay = 2;
    seen = 1'b0; extra = 1'b0;
    sb.push_back('{1'b0, 32'h500 ^ K});
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    repeat (2) @(negedge clk);
    bus.if_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.if_ready) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL drop_ready got=0 required=1");
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_req) extra = 1'b1;
    end
    total++;
    if (extra) begin
      bad++; $display("FAIL drop_regrant got=1 required=0");
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int lat, rc;
    logic [31:0] ga;
    logic sok, spur;
    ack_en = 1'b0; spur = 1'b0;
    bus.dm_read = 1'b1; bus.dm_addr = 32'h600;
    repeat (3) @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL rstmid_busy got=%b required=1", bus.mem_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL rstmid_req got=%b required=0", bus.mem_req);
    end
    bus.dm_read = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.dm_ready || bus.mem_req) spur = 1'b1;
    end
    total++;
    if (spur || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle spur=%b err=%b required=0/0",
               spur, bus.timeout_err);
    end
    sb.push_back('{1'b0, 32'h800 ^ K});
    run_if(32'h800, lat, rc, ga, sok);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL rstmid_after lat=%0d required=2", lat);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_timeout();
    test_rw_both();
    test_drop();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
